// File: rtl/lockin_test_source.sv
// Sine test source for the lock-in chain: a programmable-rate, scaled and offset sine
// with a power-of-two number of points per cycle, streamed as 64-bit samples.
module lockin_test_source #(
    parameter int ROM_DEPTH = 256,
    parameter int ROM_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    input  logic [3:0]  ptos_log2,
    input  logic [15:0] decim,
    input  logic [15:0] amplitude,
    input  logic [31:0] offset,
    input  logic [31:0] n_ciclos,
    output logic [63:0] data_out,
    output logic        data_out_valid,
    output logic        busy,
    output logic        done,
    output logic [31:0] sample_count
);

    localparam int IDX_W = $clog2(ROM_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64.
    function automatic logic [14:0] quarter_sine(input logic [6:0] k);
        case (k)
            7'd0:  quarter_sine = 15'd0;     7'd1:  quarter_sine = 15'd804;   7'd2:  quarter_sine = 15'd1608;  7'd3:  quarter_sine = 15'd2410;
            7'd4:  quarter_sine = 15'd3212;  7'd5:  quarter_sine = 15'd4011;  7'd6:  quarter_sine = 15'd4808;  7'd7:  quarter_sine = 15'd5602;
            7'd8:  quarter_sine = 15'd6393;  7'd9:  quarter_sine = 15'd7179;  7'd10: quarter_sine = 15'd7962;  7'd11: quarter_sine = 15'd8739;
            7'd12: quarter_sine = 15'd9512;  7'd13: quarter_sine = 15'd10278; 7'd14: quarter_sine = 15'd11039; 7'd15: quarter_sine = 15'd11793;
            7'd16: quarter_sine = 15'd12539; 7'd17: quarter_sine = 15'd13279; 7'd18: quarter_sine = 15'd14010; 7'd19: quarter_sine = 15'd14732;
            7'd20: quarter_sine = 15'd15446; 7'd21: quarter_sine = 15'd16151; 7'd22: quarter_sine = 15'd16846; 7'd23: quarter_sine = 15'd17530;
            7'd24: quarter_sine = 15'd18204; 7'd25: quarter_sine = 15'd18868; 7'd26: quarter_sine = 15'd19519; 7'd27: quarter_sine = 15'd20159;
            7'd28: quarter_sine = 15'd20787; 7'd29: quarter_sine = 15'd21403; 7'd30: quarter_sine = 15'd22005; 7'd31: quarter_sine = 15'd22594;
            7'd32: quarter_sine = 15'd23170; 7'd33: quarter_sine = 15'd23731; 7'd34: quarter_sine = 15'd24279; 7'd35: quarter_sine = 15'd24811;
            7'd36: quarter_sine = 15'd25329; 7'd37: quarter_sine = 15'd25832; 7'd38: quarter_sine = 15'd26319; 7'd39: quarter_sine = 15'd26790;
            7'd40: quarter_sine = 15'd27245; 7'd41: quarter_sine = 15'd27683; 7'd42: quarter_sine = 15'd28105; 7'd43: quarter_sine = 15'd28510;
            7'd44: quarter_sine = 15'd28898; 7'd45: quarter_sine = 15'd29268; 7'd46: quarter_sine = 15'd29621; 7'd47: quarter_sine = 15'd29956;
            7'd48: quarter_sine = 15'd30273; 7'd49: quarter_sine = 15'd30571; 7'd50: quarter_sine = 15'd30852; 7'd51: quarter_sine = 15'd31113;
            7'd52: quarter_sine = 15'd31356; 7'd53: quarter_sine = 15'd31580; 7'd54: quarter_sine = 15'd31785; 7'd55: quarter_sine = 15'd31971;
            7'd56: quarter_sine = 15'd32137; 7'd57: quarter_sine = 15'd32285; 7'd58: quarter_sine = 15'd32412; 7'd59: quarter_sine = 15'd32521;
            7'd60: quarter_sine = 15'd32609; 7'd61: quarter_sine = 15'd32678; 7'd62: quarter_sine = 15'd32728; 7'd63: quarter_sine = 15'd32757;
            7'd64: quarter_sine = 15'd32767;
            default: quarter_sine = 15'd0;
        endcase
    endfunction

    // Full 256-entry table folded from the first quadrant by sine symmetry.
    function automatic logic signed [ROM_WIDTH-1:0] sine_rom(input logic [IDX_W-1:0] idx);
        logic [6:0]  k_s;
        logic [14:0] mag_s;
        if (idx[6]) begin
            k_s = 7'd64 - {1'b0, idx[5:0]};
        end else begin
            k_s = {1'b0, idx[5:0]};
        end
        mag_s = quarter_sine(k_s);
        if (idx[7]) begin
            sine_rom = ROM_WIDTH'(16'd0 - {1'b0, mag_s});
        end else begin
            sine_rom = ROM_WIDTH'({1'b0, mag_s});
        end
    endfunction

    state_t                       state_r;
    logic [IDX_W-1:0]             step_r, index_r;
    logic [15:0]                  decim_r, div_r;
    logic signed [15:0]           amp_r;
    logic [31:0]                  offset_r, n_ciclos_r, cyc_r;
    logic                         v1_r;
    logic signed [ROM_WIDTH-1:0]  rom_r;

    logic [3:0]         p_s;
    logic [IDX_W-1:0]   step_s, next_idx_s;
    logic               stop_s, tick_s;
    logic signed [31:0] prod_s, scaled_s;
    logic [32:0]        sum_s;
    logic [31:0]        sat_s;

    // Step clamping, tick generation and the scale/offset/saturate arithmetic.
    always_comb begin
        if (ptos_log2 < 4'd2) begin
            p_s = 4'd2;
        end else if (ptos_log2 > 4'd8) begin
            p_s = 4'd8;
        end else begin
            p_s = ptos_log2;
        end
        step_s     = IDX_W'(9'd256 >> p_s);
        stop_s     = (n_ciclos_r != 32'd0) && (cyc_r == n_ciclos_r);
        tick_s     = (state_r == ST_RUN) && enable && !stop_s && (div_r == decim_r);
        next_idx_s = index_r + step_r;
        prod_s     = amp_r * rom_r;
        scaled_s   = prod_s >>> 15;
        sum_s      = {scaled_s[31], scaled_s} + {offset_r[31], offset_r};
        if (sum_s[32] != sum_s[31]) begin
            sat_s = sum_s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sat_s = sum_s[31:0];
        end
    end

    // Run-control FSM, divider/index/cycle counters and the two-stage sample pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            step_r         <= '0;
            index_r        <= '0;
            decim_r        <= 16'd0;
            div_r          <= 16'd0;
            amp_r          <= 16'sd0;
            offset_r       <= 32'd0;
            n_ciclos_r     <= 32'd0;
            cyc_r          <= 32'd0;
            v1_r           <= 1'b0;
            rom_r          <= '0;
            data_out       <= 64'd0;
            data_out_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sample_count   <= 32'd0;
        end else begin
            v1_r           <= tick_s;
            data_out_valid <= v1_r;
            if (tick_s) begin
                rom_r <= sine_rom(index_r);
            end
            if (v1_r) begin
                data_out     <= {{32{sat_s[31]}}, sat_s};
                sample_count <= sample_count + 32'd1;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        step_r       <= step_s;
                        decim_r      <= decim;
                        amp_r        <= amplitude;
                        offset_r     <= offset;
                        n_ciclos_r   <= n_ciclos;
                        index_r      <= '0;
                        div_r        <= 16'd0;
                        cyc_r        <= 32'd0;
                        sample_count <= 32'd0;
                        state_r      <= ST_RUN;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (enable && !stop_s) begin
                        div_r <= (div_r == decim_r) ? 16'd0 : div_r + 16'd1;
                    end
                    if (tick_s) begin
                        index_r <= next_idx_s;
                        if (next_idx_s == '0) begin
                            cyc_r <= cyc_r + 32'd1;
                        end
                    end
                    // Leave only once the final sample has cleared the ROM stage.
                    if (stop_s && !v1_r) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_test_source.sv
// Scoreboard bench for lockin_test_source: expected samples are queued from a real-valued
// sine model at each start; a negedge monitor pops and compares on every strobe.
module tb_lockin_test_source;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ptos_log2 = 4'd0;
    logic [15:0] decim = 16'd0;
    logic [15:0] amplitude = 16'd0;
    logic [31:0] offset = 32'd0;
    logic [31:0] n_ciclos = 32'd0;
    logic [63:0] data_out;
    logic        data_out_valid;
    logic        busy;
    logic        done;
    logic [31:0] sample_count;

    lockin_test_source dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
        .ptos_log2(ptos_log2), .decim(decim), .amplitude(amplitude), .offset(offset),
        .n_ciclos(n_ciclos), .data_out(data_out), .data_out_valid(data_out_valid),
        .busy(busy), .done(done), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] seen_data[$];
    int          strobe_cyc[$];
    int          rom_m[256];
    int          cyc_cnt = 0;
    int          start_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_sample(input int idx, input logic [15:0] amp, input logic [31:0] off);
        longint prod, q, s;
        prod = longint'($signed(amp)) * longint'(rom_m[idx]);
        if (prod >= 0) q = prod / 64'sd32768;
        else q = -((-prod + 64'sd32767) / 64'sd32768);
        s = q + longint'($signed(off));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return 64'(s);
    endfunction

    task automatic push_run(input logic [3:0] p, input logic [15:0] amp, input logic [31:0] off,
                            input logic [31:0] n, input int cont_total, output int total);
        int pe, pts;
        exp_t e;
        pe    = (p < 2) ? 2 : ((p > 8) ? 8 : int'(p));
        pts   = 1 << pe;
        total = (n == 32'd0) ? cont_total : int'(n) * pts;
        for (int k = 0; k < total; k++) begin
            e.data = model_sample((k * (256 / pts)) % 256, amp, off);
            e.cnt  = 32'(k + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [3:0] p, input logic [15:0] dc, input logic [15:0] amp,
                             input logic [31:0] off, input logic [31:0] n, input int cont_total,
                             output int total);
        @(negedge clk);
        ptos_log2 = p; decim = dc; amplitude = amp; offset = off; n_ciclos = n; start = 1'b1;
        seen_data.delete();
        strobe_cyc.delete();
        start_cyc = cyc_cnt;
        push_run(p, amp, off, n, cont_total, total);
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs: the run must keep using the latched configuration.
        ptos_log2 = 4'($urandom); decim = 16'($urandom); amplitude = 16'($urandom);
        offset = $urandom; n_ciclos = $urandom;
    endtask

    task automatic wait_done(input string name, input int bound, input bit rand_en);
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (rand_en) enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
        chk({name, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic wait_strobes(input string name, input int n, input int bound);
        for (int i = 0; i < bound && seen_data.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk({name, "_strobes_seen"}, 64'(seen_data.size() >= n), 64'd1);
    endtask

    task automatic finish_run(input string name, input int total);
        chk({name, "_strobe_total"}, 64'(seen_data.size()), 64'(total));
        chk({name, "_sample_count"}, 64'(sample_count), 64'(total));
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && data_out_valid) begin
            seen_data.push_back(data_out);
            strobe_cyc.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got data %h, expected no strobe", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("sample_data", data_out, e.data);
                chk("strobe_sample_count", 64'(sample_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        int total, held;
        bit done_seen;
        real r;
        for (int i = 0; i < 256; i++) begin
            r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
            rom_m[i] = $rtoi($floor(r + 0.5));
        end

        #2 reset_n = 1'b0;
        #1;
        chk("reset_data_out", data_out, 64'd0);
        chk("reset_valid", 64'(data_out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sample_count", 64'(sample_count), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        start_run(4'd2, 16'd0, 16'd32767, 32'd0, 32'd2, 0, total);
        wait_done("basic", 200, 1'b0);
        chk("basic_first_latency", 64'(strobe_cyc.size() > 0 ? strobe_cyc[0] - start_cyc : -1), 64'd3);
        chk("basic_back_to_back", 64'(strobe_cyc.size() == 8 ? strobe_cyc[7] - strobe_cyc[0] : -1), 64'd7);
        chk("basic_sample1", seen_data.size() > 1 ? seen_data[1] : 64'hX, 64'd32766);
        chk("basic_sample3", seen_data.size() > 3 ? seen_data[3] : 64'hX, 64'hFFFF_FFFF_FFFF_8001);
        finish_run("basic", total);

        start_run(4'd2, 16'd3, 16'd32767, 32'd0, 32'd2, 0, total);
        wait_done("decim", 400, 1'b0);
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk("decim_spacing", 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd4);
        finish_run("decim", total);

        start_run(4'd2, 16'd0, 16'd32767, 32'h7FFF_FFF0, 32'd1, 0, total);
        wait_done("sat", 200, 1'b0);
        chk("sat_sample1", seen_data.size() > 1 ? seen_data[1] : 64'hX, 64'h0000_0000_7FFF_FFFF);
        chk("sat_sample3", seen_data.size() > 3 ? seen_data[3] : 64'hX, 64'h0000_0000_7FFF_7FF1);
        finish_run("sat", total);

        start_run(4'd2, 16'd5, 16'd32767, 32'd0, 32'd1, 0, total);
        wait_strobes("gap", 2, 200);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("gap_no_strobes", 64'(seen_data.size()), 64'd2);
        enable = 1'b1;
        wait_done("gap", 400, 1'b0);
        chk("gap_resume_sample", seen_data.size() > 2 ? seen_data[2] : 64'hX, 64'd0);
        finish_run("gap", total);

        start_run(4'd3, 16'd1, 16'($urandom), $urandom, 32'd2, 0, total);
        wait_strobes("rst", 3, 200);
        reset_n = 1'b0;
        #1;
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_valid", 64'(data_out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sample_count", 64'(sample_count), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        held = seen_data.size();
        repeat (20) @(negedge clk);
        #1;
        chk("rst_idle_busy", 64'(busy), 64'd0);
        chk("rst_idle_no_strobes", 64'(seen_data.size()), 64'(held));

        for (int r_i = 0; r_i < 8; r_i++) begin
            logic [31:0] off;
            off = $urandom;
            if (r_i % 4 == 1) off = 32'h7FFF_C000 + 32'($urandom_range(0, 32767));
            if (r_i % 4 == 2) off = 32'h8000_0000 + 32'($urandom_range(0, 32767));
            start_run(4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)), 16'($urandom), off,
                      32'($urandom_range(1, 2)), 0, total);
            wait_done("rand", 8000, 1'b1);
            finish_run("rand", total);
        end

        start_run(4'($urandom_range(0, 15)), 16'd0, 16'($urandom), $urandom, 32'd0, 1100, total);
        wait_strobes("cont_pre", 5, 100);
        @(negedge clk);
        ptos_log2 = 4'd8; offset = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 3000 && seen_data.size() < 1000; i++) begin
            @(negedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        chk("cont_1000_strobes", 64'(seen_data.size() >= 1000), 64'd1);
        chk("cont_done_never", 64'(done_seen), 64'd0);
        chk("cont_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
